// File: rtl/freq_gate_counter_if.sv
// Bundle between the frequency-counter control FSM, the Fx input and the
// display stage. Master drives the measurement controls; slave is the datapath.
interface freq_gate_counter_if;
  logic        Fx;
  logic        reset;
  logic [1:0]  std_f_sel;
  logic [2:0]  range;
  logic        Cntover;
  logic        Cntlow;
  logic        done;
  logic [15:0] bcd_out;
  logic [2:0]  range_out;
  logic        gate;

  modport master (
    output Fx, reset, std_f_sel, range,
    input  Cntover, Cntlow, done, bcd_out, range_out, gate
  );

  modport slave (
    input  Fx, reset, std_f_sel, range,
    output Cntover, Cntlow, done, bcd_out, range_out, gate
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated Fx edge counter: counts synchronized rising edges of Fx in BCD over a
// gate window chosen by std_f_sel, then latches the result for the display.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | gate closed, waiting for reset=0 from the control FSM
//   S_GATE  | gate open, down-counter running, edges counted
//   S_LATCH | one cycle: result/range latched, done + range flags pulse
module freq_gate_counter #(
  parameter int unsigned GATE_CYC_0 = 1000,
  parameter int unsigned GATE_CYC_1 = 10000,
  parameter int unsigned GATE_CYC_3 = 100000,
  parameter int unsigned GATE_W     = 17
) (
  input  logic               Clk,
  input  logic               Clear_n,
  freq_gate_counter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_LATCH} state_t;

  localparam logic [GATE_W-1:0] LOAD_0 = GATE_W'(GATE_CYC_0 - 1);
  localparam logic [GATE_W-1:0] LOAD_1 = GATE_W'(GATE_CYC_1 - 1);
  localparam logic [GATE_W-1:0] LOAD_3 = GATE_W'(GATE_CYC_3 - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1, r_sync2, r_sync3;
  logic              w_rise;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [GATE_W-1:0] w_load;
  logic [15:0]       r_bcd;
  logic [15:0]       w_bcd_inc;
  logic [15:0]       w_bcd_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic              w_cnt_en;
  logic              w_start;
  logic              w_latch;
  logic [2:0]        r_rng_hold;
  logic              r_gate, r_done, r_cntover, r_cntlow;
  logic [15:0]       r_bcd_out;
  logic [2:0]        r_range_out;

  // Edge is seen after two synchronizer stages; the third flop gives the prior value.
  assign w_rise   = r_sync2 & ~r_sync3;
  assign w_cnt_en = (r_state == S_GATE) && w_rise;
  // A new window opens from IDLE or directly from LATCH (back-to-back gates).
  assign w_start  = (w_state_nxt == S_GATE) && (r_state != S_GATE);
  assign w_latch  = (w_state_nxt == S_LATCH);

  // 2'b10 never comes from the FSM; it aliases to the 2'b01 gate length.
  always_comb begin
    w_load = LOAD_1;
    if (bus.std_f_sel == 2'b00)      w_load = LOAD_0;
    else if (bus.std_f_sel == 2'b11) w_load = LOAD_3;
  end

  // Ripple-carry BCD +1 across the four digits.
  always_comb begin
    logic w_carry;
    w_carry   = 1'b1;
    w_bcd_inc = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  // Next count including this cycle's edge, so an edge in the last gate cycle reaches the latch.
  always_comb begin
    w_bcd_nxt = r_bcd;
    w_ovf_nxt = r_ovf;
    if (w_cnt_en) begin
      if (r_bcd == 16'h9999) w_ovf_nxt = 1'b1;
      else                   w_bcd_nxt = w_bcd_inc;
    end
  end

  // Next-state logic; abort on reset takes priority over gate expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!bus.reset) w_state_nxt = S_GATE;
      S_GATE: begin
        if (bus.reset)               w_state_nxt = S_IDLE;
        else if (r_gate_cnt == '0)   w_state_nxt = S_LATCH;
      end
      S_LATCH: w_state_nxt = bus.reset ? S_IDLE : S_GATE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Clear_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Fx synchronizer and edge-detect pipeline.
  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.Fx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Gate down-counter, BCD counter, overflow flag and range hold.
  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      r_gate_cnt <= '0;
      r_bcd      <= 16'h0000;
      r_ovf      <= 1'b0;
      r_rng_hold <= 3'b000;
    end else if (w_start) begin
      r_gate_cnt <= w_load;
      r_bcd      <= 16'h0000;
      r_ovf      <= 1'b0;
      r_rng_hold <= bus.range;
    end else if (r_state == S_GATE) begin
      if (r_gate_cnt != '0) r_gate_cnt <= r_gate_cnt - GATE_W'(1);
      r_bcd <= w_bcd_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Registered outputs: pulses are high exactly while the FSM sits in LATCH.
  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      r_gate      <= 1'b0;
      r_done      <= 1'b0;
      r_cntover   <= 1'b0;
      r_cntlow    <= 1'b0;
      r_bcd_out   <= 16'h0000;
      r_range_out <= 3'b000;
    end else begin
      r_gate    <= (w_state_nxt == S_GATE);
      r_done    <= w_latch;
      r_cntover <= w_latch && w_ovf_nxt;
      r_cntlow  <= w_latch && !w_ovf_nxt && (w_bcd_nxt[15:12] == 4'd0);
      if (w_latch) begin
        r_bcd_out   <= w_ovf_nxt ? 16'h9999 : w_bcd_nxt;
        r_range_out <= r_rng_hold;
      end
    end
  end

  assign bus.gate      = r_gate;
  assign bus.done      = r_done;
  assign bus.Cntover   = r_cntover;
  assign bus.Cntlow    = r_cntlow;
  assign bus.bcd_out   = r_bcd_out;
  assign bus.range_out = r_range_out;

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Measurement datapath directly downstream of the frequency-counter control FSM.
- Consumes the FSM's `reset`, `std_f_sel` and `range` outputs.
- Counts rising edges of the unknown signal Fx over a gate window whose length is set by `std_f_sel`, latches a 4-digit BCD result plus range for the display stage, and returns `Cntover`/`Cntlow` to the FSM for autoranging.

Parameters:
- GATE_CYC_0, 1000, gate length in Clk cycles when std_f_sel=2'b00
- GATE_CYC_1, 10000, gate length in Clk cycles when std_f_sel=2'b01 (also used for 2'b10)
- GATE_CYC_3, 100000, gate length in Clk cycles when std_f_sel=2'b11
- GATE_W, 17, width of gate down-counter; must hold the largest GATE_CYC_*

Ports:
- Clk  input  1  sole clock, rising edge
- Clear_n  input  1  synchronous active-low reset
- Fx  input  1  asynchronous signal under measurement; frequency must be < Clk/4
- reset  input  1  from control FSM; 1 = prepare/clear phase, 0 = measure enable
- std_f_sel  input  2  gate select from control FSM
- range  input  3  decimal-point/range code from control FSM
- Cntover  output  1  one-cycle pulse: count exceeded 9999 in the last gate
- Cntlow  output  1  one-cycle pulse: count < 1000 in the last gate, no overflow
- done  output  1  one-cycle pulse: new result latched
- bcd_out  output  16  latched result, 4 BCD digits, [15:12] most significant
- range_out  output  3  range code latched with bcd_out
- gate  output  1  1 while the gate window is open (debug/LED)

Behaviour:
- Reset: Clear_n=0 at a Clk edge puts the state machine in IDLE and clears all of the following to 0:
  - Cntover, Cntlow, done, gate
  - bcd_out = 16'h0000, range_out = 3'b000
  - internal BCD counter, overflow flag and synchronizer flops
- Fx path:
  - Two-flop synchronizer, then a third flop for edge detection.
  - A rising edge is recognised 3 Clk cycles after the Fx transition.
  - A recognised edge counts only while gate=1.
- State machine, states IDLE, GATE, LATCH:
  - IDLE: gate=0. If reset=0, go to GATE next cycle. On entering GATE:
    - load the gate counter with GATE_CYC_sel-1;
    - clear the BCD counter and overflow flag;
    - sample std_f_sel and range into hold registers.
  - GATE: gate=1 for exactly GATE_CYC_sel cycles. The down-counter decrements each cycle. At 0 the next state is LATCH.
  - LATCH (one cycle): gate=0.
    - bcd_out ← counter (or 16'h9999 if overflowed).
    - range_out ← held range.
    - done=1.
    - Cntover=1 if overflow.
    - Cntlow=1 if no overflow and digit[15:12]==0.
    - Next state is GATE if reset=0 (restart immediately, same reload rules), otherwise IDLE.
- Outputs Cntover, Cntlow and done are registered. They are high only in the cycle the state machine is in LATCH, and never high simultaneously with each other except done.
- BCD counter:
  - Each digit wraps 9→0 with carry into the next digit.
  - On an edge at 9999, set the overflow flag (sticky until the next gate start); the counter saturates at 9999.
- reset=1 while in GATE: abort to IDLE on the next cycle, gate drops.
  - No done, Cntover or Cntlow pulse.
  - bcd_out and range_out keep their previous values.
- reset=1 during LATCH: the latch and pulses still occur; the next state is IDLE.
- An edge recognised in the final GATE cycle is counted. An edge recognised in LATCH or IDLE is discarded.
- std_f_sel or range changing mid-gate has no effect until the next gate start.
- std_f_sel=2'b10 is illegal from the FSM and is treated as 2'b01.
- Result latency: done occurs GATE_CYC_sel+1 cycles after GATE entry.

Test Plan:
- Reset and idle:
  - Stimulus: hold Clear_n=0 for 3 cycles with Fx toggling, then release with reset=1.
  - Required: all outputs 0, gate stays 0.
- Normal count (GATE_CYC_1=10000 overridden to 1000, std_f_sel=01, range=3'b010, Fx period 8 Clk, reset=0):
  - Required: done after 1001 cycles; bcd_out=16'h0125, range_out=3'b010; Cntlow=1, Cntover=0.
- Overflow (GATE_CYC_0=50000, Fx period 4 Clk):
  - Required: 12500 edges give bcd_out=16'h9999, Cntover=1, Cntlow=0.
- In-range (Fx period 4, gate 20000):
  - Required: bcd_out=16'h5000; no Cntover, no Cntlow; a second consecutive gate starts the cycle after done.
- Abort:
  - Stimulus: assert reset=1 midway through GATE.
  - Required: gate=0 next cycle, no done pulse, bcd_out unchanged.
- Boundary edge:
  - Stimulus: place a recognised Fx edge in the last GATE cycle and another in LATCH.
  - Required: exactly one of the two is counted (count increments by 1 vs. the baseline).
